pic_host_sequencer: RTL

PIC_HOST_SEQUENCER -- requirements
Module: pic_host_sequencer

---
 rtl/pic_host_sequencer.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pic_host_sequencer.sv
// Host-side bus sequencer for an 8259-style PIC: ICW init sequence, OCW writes and status reads.
// Optional macro PIC_HOST_READBACK_EN enables the status read path (RD strobe, readData/readValid).
module pic_host_sequencer #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cfgICW1,
  input  logic [7:0] cfgICW2,
  input  logic [7:0] cfgICW3,
  input  logic [7:0] cfgICW4,
  input  logic       ocwReq,
  input  logic [1:0] ocwSel,
  input  logic [7:0] ocwData,
  input  logic       readReq,
  input  logic       readA0,
  input  logic [7:0] busIn,
  output logic [7:0] globalBus,
  output logic       busOe,
  output logic       A0,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic       busy,
  output logic       initDone,
  output logic       ocwAck,
  output logic [7:0] readData,
  output logic       readValid,
  output logic       errPulse
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_ICW1 = 3'd0,
    OP_ICW2 = 3'd1,
    OP_ICW3 = 3'd2,
    OP_ICW4 = 3'd3,
    OP_OCW  = 3'd4,
    OP_READ = 3'd5
  } op_t;

  // Returns {A0, data} for an OCW; OCW2/OCW3 carry a fixed select code in bits 4:3.
  function automatic logic [8:0] ocw_map(input logic [1:0] sel, input logic [7:0] d);
    logic [8:0] r;
    case (sel)
      2'd1:    r = {1'b1, d};
      2'd2:    r = {1'b0, d[7:5], 2'b00, d[2:0]};
      2'd3:    r = {1'b0, d[7:5], 2'b01, d[2:0]};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  op_t        op_q, op_d, next_op_s;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] bus_q, bus_d;
  logic       a0_q, a0_d;
  logic       oe_q, oe_d;
  logic       cs_q, cs_d;
  logic       wr_q, wr_d;
  logic       busy_q, busy_d;
  logic       init_q, init_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       has_next_s;
  logic       final_icw_s;
  logic       rd_req_s;
  logic       in_access_s;
  logic [7:0] next_icw_data_s;
  logic [8:0] ocw_word_s;

  assign ocw_word_s = ocw_map(ocwSel, ocwData);

  // Decide which ICW follows the current one (mode_q holds cfgICW1[1:0]: SNGL, IC4)
  always_comb begin
    has_next_s = 1'b0;
    next_op_s  = OP_ICW2;
    case (op_q)
      OP_ICW1: begin
        has_next_s = 1'b1;
        next_op_s  = OP_ICW2;
      end
      OP_ICW2: begin
        if (!mode_q[1]) begin
          has_next_s = 1'b1;
          next_op_s  = OP_ICW3;
        end else if (mode_q[0]) begin
          has_next_s = 1'b1;
          next_op_s  = OP_ICW4;
        end else begin
          has_next_s = 1'b0;
        end
      end
      OP_ICW3: begin
        if (mode_q[0]) begin
          has_next_s = 1'b1;
          next_op_s  = OP_ICW4;
        end else begin
          has_next_s = 1'b0;
        end
      end
      default: has_next_s = 1'b0;
    endcase
    case (next_op_s)
      OP_ICW2: next_icw_data_s = cfgICW2;
      OP_ICW3: next_icw_data_s = cfgICW3;
      default: next_icw_data_s = cfgICW4;
    endcase
    final_icw_s = ((op_q == OP_ICW2) || (op_q == OP_ICW3) || (op_q == OP_ICW4)) && !has_next_s;
  end

  // Next-state and next-output logic; outputs are registered from the next state
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    bus_d   = bus_q;
    a0_d    = a0_q;
    init_d  = init_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          op_d    = OP_ICW1;
          mode_d  = cfgICW1[1:0];
          init_d  = 1'b0;
          a0_d    = 1'b0;
          bus_d   = cfgICW1 | 8'h10;
        end else if (ocwReq) begin
          if (!init_q || (ocwSel == 2'd0)) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_SETUP;
            op_d    = OP_OCW;
            a0_d    = ocw_word_s[8];
            bus_d   = ocw_word_s[7:0];
          end
        end else if (rd_req_s) begin
          state_d = ST_SETUP;
          op_d    = OP_READ;
          a0_d    = readA0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = 4'd0;
      end
      ST_STROBE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_GAP;
        cnt_d   = 4'd0;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (has_next_s) begin
            state_d = ST_SETUP;
            op_d    = next_op_s;
            a0_d    = 1'b1;
            bus_d   = next_icw_data_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // initDone rises as the final ICW enters its last GAP clock
    init_d = init_d | ((state_d == ST_GAP) && (cnt_d == GAP_LAST) && final_icw_s);
    in_access_s = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    cs_d   = !in_access_s;
    wr_d   = !((state_d == ST_STROBE) && (op_d != OP_READ));
    oe_d   = in_access_s && (op_d != OP_READ);
    busy_d = (state_d != ST_IDLE);
    ack_d  = (state_d == ST_HOLD) && (op_d == OP_OCW);
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ICW1;
      cnt_q   <= 4'd0;
      mode_q  <= 2'b00;
      bus_q   <= 8'h00;
      a0_q    <= 1'b0;
      oe_q    <= 1'b0;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      bus_q   <= bus_d;
      a0_q    <= a0_d;
      oe_q    <= oe_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      init_q  <= init_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign globalBus = bus_q;
  assign busOe     = oe_q;
  assign A0        = a0_q;
  assign CS        = cs_q;
  assign WR        = wr_q;
  assign busy      = busy_q;
  assign initDone  = init_q;
  assign ocwAck    = ack_q;
  assign errPulse  = err_q;

`ifdef PIC_HOST_READBACK_EN
  logic       rd_q, rd_d;
  logic       rv_q, rv_d;
  logic [7:0] rdata_q, rdata_d;

  assign rd_req_s = readReq;

  // RD strobe, busIn capture on the final strobe clock, valid pulse during HOLD
  always_comb begin
    rd_d = !((state_d == ST_STROBE) && (op_d == OP_READ));
    rv_d = (state_d == ST_HOLD) && (op_d == OP_READ);
    if ((state_q == ST_STROBE) && (op_q == OP_READ) && (cnt_q == PULSE_LAST)) begin
      rdata_d = busIn;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read-path flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= 1'b1;
      rv_q    <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      rd_q    <= rd_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  assign RD        = rd_q;
  assign readValid = rv_q;
  assign readData  = rdata_q;
`else
  logic unused_rd_s;

  assign rd_req_s    = 1'b0;
  assign unused_rd_s = ^{readReq, busIn};
  assign RD          = 1'b1;
  assign readValid   = 1'b0;
  assign readData    = 8'h00;
`endif

endmodule
